pio_apb_bridge: RTL and testbench
=================================

PIO_APB_BRIDGE -- requirements
Module: pio_apb_bridge

Interface
REQ-001 The block SHALL have parameter MAX_OFF, default 12'h140: highest legal word-aligned register offset.
REQ-002 The block SHALL have parameter BUSY_TMO, default 16: maximum consecutive busy cycles before the access is aborted.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port psel, input, 1 bit: APB select.
REQ-006 The block SHALL have port penable, input, 1 bit: APB access phase.
REQ-007 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port paddr, input, 14 bits: [13:12] alias (00 normal, 01 XOR, 10 SET, 11 CLR); [11:0] byte offset.
REQ-009 The block SHALL have port pwdata, input, 32 bits: APB write data.
REQ-010 The block SHALL have port prdata, output, 32 bits: APB read data.
REQ-011 The block SHALL have port pready, output, 1 bit: transfer complete.
REQ-012 The block SHALL have port pslverr, output, 1 bit: transfer error, valid only while pready=1.
REQ-013 The block SHALL have port sel, output, 1 bit: register-file select.
REQ-014 The block SHALL have port RW, output, 1 bit: 1 = register write, 0 = register read.
REQ-015 The block SHALL have port addr, output, 12 bits: register offset, equal to paddr[11:0].
REQ-016 The block SHALL have port wdata, output, 32 bits: register write data.
REQ-017 The block SHALL have port rdata, input, 32 bits: register read data, valid the cycle after a read request.
REQ-018 The block SHALL have port busy, input, 1 bit: register file stall; the current request is held while busy=1.

Function
REQ-019 The FSM SHALL use states IDLE, RD, RD_CAP, WR, DONE.
REQ-020 In IDLE, psel=1 with penable=0 SHALL latch paddr, pwrite and pwdata; a sample with psel=0, or with psel=1 and penable=1, SHALL be ignored.
REQ-021 Error check at latch: paddr[1:0]!=0 or paddr[11:0]>MAX_OFF SHALL set err and go to DONE with no register access.
REQ-022 Otherwise, a write with alias 00 SHALL go to WR; a read (alias ignored) or a write with alias !=00 SHALL go to RD.
REQ-023 RD SHALL drive sel=1, RW=0, addr; it SHALL stay while busy=1 and go to RD_CAP when busy=0.
REQ-024 RD_CAP SHALL capture rdata into the holding register; a read SHALL then go to DONE and an alias write SHALL go to WR.
REQ-025 WR SHALL drive sel=1, RW=1, addr, wdata; it SHALL stay while busy=1 and go to DONE when busy=0.
REQ-026 wdata SHALL be pwdata for alias 00, cap^pwdata for XOR, cap|pwdata for SET, cap&~pwdata for CLR.
REQ-027 DONE SHALL assert pready=1 for exactly one cycle, with prdata=capture (0 for writes and errors) and pslverr=err, then go to IDLE.
REQ-028 sel SHALL be 0 in IDLE, RD_CAP and DONE; each register access SHALL produce exactly one sel cycle once busy is low.
REQ-029 Zero-busy latency from the setup cycle T0: normal write pready at T2; read at T3; alias RMW at T4; error at T1.
REQ-030 A counter SHALL count consecutive busy=1 cycles in RD or WR; on reaching BUSY_TMO it SHALL go to DONE with err=1 and no write issued; the counter SHALL clear on every state change.
REQ-031 The bridge SHALL accept no new transfer outside IDLE; psel/paddr changes during an access SHALL be ignored.
REQ-032 Outputs SHALL be Moore-decoded from state and latched registers; no combinational path SHALL exist from APB inputs to sel/RW/addr/wdata.

Reset
REQ-033 While reset=1 at a clock edge, state SHALL become IDLE, and err, capture, latched address/data and the busy counter SHALL clear to 0.
REQ-034 sel, RW, pready, pslverr and prdata SHALL be forced to 0 during any cycle in which reset=1, including mid-access; an aborted access SHALL never complete or issue a write.

Verification
REQ-035 Bench: write 0x140 <- 0x1234_5678, alias 00, busy=0 -> one sel/RW=1 cycle at addr 0x140, wdata 0x1234_5678; pready at T2, pslverr=0.
REQ-036 Bench: regfile holds 0x0000_00F0 at 0x0C8; SET write 0x0000_000F, then CLR write 0x0000_0030 -> writes 0x0000_00FF then 0x0000_00CF; pready at T4 each time.
REQ-037 Bench: read 0x0D0, busy held high 3 cycles in RD -> exactly one read accepted; prdata equals regfile value; pready at T6.
REQ-038 Bench: access to 0x142 and to 0x144 -> pready at T1, pslverr=1, prdata=0, sel never asserted.
REQ-039 Bench: busy stuck at 1 during a write -> pready with pslverr=1 after 16 busy cycles, no RW=1 accepted.
REQ-040 Bench: reset asserted in RD_CAP of an XOR write -> no write issued, pready stays 0, next transfer completes normally.

Source files
------------

// File: rtl/pio_apb_bridge.sv
// APB slave to simple register-file bridge with read-modify-write aliases (XOR/SET/CLR).
// Latency (busy=0): write 2 cycles, read 3, alias RMW 4, decode error 1 from the setup cycle.
// Backpressure: busy holds the pending register access; BUSY_TMO consecutive busy cycles abort with an error.
module pio_apb_bridge #(
    parameter logic [11:0] MAX_OFF  = 12'h140,
    parameter int          BUSY_TMO = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [13:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        sel,
    output logic        RW,
    output logic [11:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        busy
);

    localparam int BCW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RD_CAP = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [11:0]     addr_q;
    logic [1:0]      alias_q;
    logic            wr_q;
    logic [31:0]     wdat_q;
    logic [31:0]     cap_q;
    logic            err_q;
    logic [BCW-1:0]  bcnt;

    logic            start;
    logic            bad;
    logic            tmo_hit;
    logic [31:0]     wr_val;

    // Only a setup-phase sample in IDLE opens a transfer; misaligned or out-of-range offsets fail at once.
    assign start   = psel && !penable;
    assign bad     = (paddr[1:0] != 2'b00) || (paddr[11:0] > MAX_OFF);
    assign tmo_hit = busy && (bcnt == BCW'(BUSY_TMO - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: alias writes take the read path first to fetch the old value.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (bad) begin
                        state_nxt = DONE;
                    end else if (pwrite && (paddr[13:12] == 2'b00)) begin
                        state_nxt = WR;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                if (busy) begin
                    state_nxt = tmo_hit ? DONE : RD;
                end else begin
                    state_nxt = RD_CAP;
                end
            end
            RD_CAP: state_nxt = wr_q ? WR : DONE;
            WR: begin
                if (busy) begin
                    state_nxt = tmo_hit ? DONE : WR;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, read capture, error flag and busy-run counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            alias_q <= '0;
            wr_q    <= 1'b0;
            wdat_q  <= '0;
            cap_q   <= '0;
            err_q   <= 1'b0;
            bcnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= paddr[11:0];
                        alias_q <= paddr[13:12];
                        wr_q    <= pwrite;
                        wdat_q  <= pwdata;
                        cap_q   <= '0;
                        err_q   <= bad;
                    end
                end
                RD_CAP: cap_q <= rdata;
                RD, WR: begin
                    if (tmo_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (state != state_nxt) begin
                bcnt <= '0;
            end else if (((state == RD) || (state == WR)) && busy) begin
                bcnt <= bcnt + BCW'(1);
            end
        end
    end

    // Merge of the captured value with the write data for the alias windows.
    always_comb begin
        case (alias_q)
            2'b01:   wr_val = cap_q ^ wdat_q;
            2'b10:   wr_val = cap_q | wdat_q;
            2'b11:   wr_val = cap_q & ~wdat_q;
            default: wr_val = wdat_q;
        endcase
    end

    // Moore outputs from state and latched registers; reset blanks everything mid-access.
    always_comb begin
        sel     = 1'b0;
        RW      = 1'b0;
        wdata   = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        addr    = addr_q;
        if (!reset) begin
            case (state)
                RD: sel = 1'b1;
                WR: begin
                    sel   = 1'b1;
                    RW    = 1'b1;
                    wdata = wr_val;
                end
                DONE: begin
                    pready  = 1'b1;
                    pslverr = err_q;
                    prdata  = (wr_q || err_q) ? 32'd0 : cap_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_apb_bridge.sv
module tb_pio_apb_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [13:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        sel;
    logic        RW;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    pio_apb_bridge #(.MAX_OFF(12'h140), .BUSY_TMO(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .sel     (sel),
        .RW      (RW),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Register file model plus access counters.
    logic [31:0] mem [0:1023];
    int          nsel;
    int          nacc;
    int          nw;
    logic [11:0] last_waddr;
    logic [31:0] last_wdata;
    int          busy_left;

    always @(posedge clk) begin
        if (sel) nsel <= nsel + 1;
        if (sel && !busy) nacc <= nacc + 1;
        if (sel && !RW && !busy) rdata <= mem[addr[11:2]];
        if (sel && RW && !busy) begin
            mem[addr[11:2]] <= wdata;
            nw         <= nw + 1;
            last_waddr <= addr;
            last_wdata <= wdata;
        end
    end

    // busy stays high for busy_left cycles of sel=1.
    always @(negedge clk) begin
        busy = (busy_left > 0);
        if (sel && busy_left > 0) busy_left = busy_left - 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [13:0] pa;
        logic [31:0] pd;
        int          busy_n;
        int          lat;
        logic        err;
        logic [31:0] rd;
        int          n_sel;
        int          n_acc;
        int          n_w;
        logic [11:0] waddr;
        logic [31:0] wdat;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int          lat;
        logic        got_err;
        logic [31:0] got_rd;
        @(negedge clk);
        nsel = 0; nacc = 0; nw = 0;
        busy_left = v.busy_n;
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.pa; pwdata = v.pd;
        @(negedge clk);
        penable = 1'b1;
        lat = 1;
        while (!pready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        got_err = pslverr;
        got_rd  = prdata;
        chk($sformatf("v%0d latency", idx), lat, v.lat);
        chk($sformatf("v%0d pslverr", idx), {31'd0, got_err}, {31'd0, v.err});
        chk($sformatf("v%0d prdata", idx), got_rd, v.rd);
        @(negedge clk);
        chk($sformatf("v%0d pready one cycle", idx), {31'd0, pready}, 32'd0);
        psel = 1'b0; penable = 1'b0;
        busy_left = 0;
        chk($sformatf("v%0d sel cycles", idx), nsel, v.n_sel);
        chk($sformatf("v%0d accepted", idx), nacc, v.n_acc);
        chk($sformatf("v%0d writes", idx), nw, v.n_w);
        if (v.n_w > 0) begin
            chk($sformatf("v%0d waddr", idx), {20'd0, last_waddr}, {20'd0, v.waddr});
            chk($sformatf("v%0d wdata", idx), last_wdata, v.wdat);
        end
        @(negedge clk);
    endtask

    vec_t tbl [12];
    int   seen_rdy;

    initial begin
        //          wr  paddr     pwdata        busy lat err prdata        sel acc w  waddr   wdata
        tbl[0]  = '{1'b1, 14'h0140, 32'h1234_5678, 0,    2,  1'b0, 32'h0,         1,  1,  1, 12'h140, 32'h1234_5678};
        tbl[1]  = '{1'b1, 14'h20C8, 32'h0000_000F, 0,    4,  1'b0, 32'h0,         2,  2,  1, 12'h0C8, 32'h0000_00FF};
        tbl[2]  = '{1'b1, 14'h30C8, 32'h0000_0030, 0,    4,  1'b0, 32'h0,         2,  2,  1, 12'h0C8, 32'h0000_00CF};
        tbl[3]  = '{1'b0, 14'h00D0, 32'h0,         3,    6,  1'b0, 32'hCAFE_BABE, 4,  1,  0, 12'h0,   32'h0};
        tbl[4]  = '{1'b0, 14'h0142, 32'h0,         0,    1,  1'b1, 32'h0,         0,  0,  0, 12'h0,   32'h0};
        tbl[5]  = '{1'b1, 14'h0144, 32'hFFFF_FFFF, 0,    1,  1'b1, 32'h0,         0,  0,  0, 12'h0,   32'h0};
        tbl[6]  = '{1'b1, 14'h10C8, 32'h0000_00FF, 0,    4,  1'b0, 32'h0,         2,  2,  1, 12'h0C8, 32'h0000_0030};
        tbl[7]  = '{1'b0, 14'h00C8, 32'h0,         0,    3,  1'b0, 32'h0000_0030, 1,  1,  0, 12'h0,   32'h0};
        tbl[8]  = '{1'b1, 14'h0040, 32'h0000_0001, 1000, 17, 1'b1, 32'h0,         16, 0,  0, 12'h0,   32'h0};
        tbl[9]  = '{1'b0, 14'h10D0, 32'h0,         0,    3,  1'b0, 32'hCAFE_BABE, 1,  1,  0, 12'h0,   32'h0};
        tbl[10] = '{1'b0, 14'h00D0, 32'h0,         1000, 17, 1'b1, 32'h0,         16, 0,  0, 12'h0,   32'h0};
        tbl[11] = '{1'b1, 14'h0000, 32'hA5A5_0001, 2,    4,  1'b0, 32'h0,         3,  1,  1, 12'h000, 32'hA5A5_0001};

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[12'h0C8 >> 2] = 32'h0000_00F0;
        mem[12'h0D0 >> 2] = 32'hCAFE_BABE;
        rdata = '0; busy = 1'b0; busy_left = 0;
        nsel = 0; nacc = 0; nw = 0; last_waddr = '0; last_wdata = '0;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset pready", {31'd0, pready}, 32'd0);
        chk("reset pslverr", {31'd0, pslverr}, 32'd0);
        chk("reset sel", {31'd0, sel}, 32'd0);
        chk("reset prdata", prdata, 32'd0);
        chk("reset addr", {20'd0, addr}, 32'd0);

        for (int i = 0; i < 12; i++) run_vec(i, tbl[i]);

        // Reset lands while an XOR write sits in RD_CAP: the write must never happen.
        @(negedge clk);
        nsel = 0; nacc = 0; nw = 0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 14'h10C8; pwdata = 32'h0000_0001;
        @(negedge clk);
        penable = 1'b1;
        chk("rst-mid sel in RD", {31'd0, sel}, 32'd1);
        @(negedge clk);
        chk("rst-mid sel in RD_CAP", {31'd0, sel}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst-mid pready forced", {31'd0, pready}, 32'd0);
        chk("rst-mid sel forced", {31'd0, sel}, 32'd0);
        @(negedge clk);
        reset = 1'b0; psel = 1'b0; penable = 1'b0;
        seen_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (pready || sel) seen_rdy++;
        end
        chk("rst-mid no activity", seen_rdy, 0);
        chk("rst-mid writes", nw, 0);
        chk("rst-mid mem", mem[12'h0C8 >> 2], 32'h0000_0030);

        run_vec(12, '{1'b0, 14'h00C8, 32'h0, 0, 3, 1'b0, 32'h0000_0030, 1, 1, 0, 12'h0, 32'h0});
        run_vec(13, '{1'b1, 14'h10C8, 32'h0000_0001, 0, 4, 1'b0, 32'h0, 2, 2, 1, 12'h0C8, 32'h0000_0031});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
